dice_traffic_gen: RTL and testbench
===================================

Name: dice_traffic_gen

Overview:
- Parametrised successor to the dice/traffic-light multiplexer.
- Two independent engines run concurrently:
  - an N-sided dice roller that reports each completed roll;
  - a four-phase traffic-light sequencer with a programmable dwell time per phase.
- `sel` chooses which engine drives `result`.
- Sits between the board button/switch inputs and the LED/7-seg display logic.

Parameters:
- FACES, 6, number of dice faces; legal 2..255. Dice values are 1..FACES.
- RED_CYC, 4, cycles spent in RED (100); must be ≥1.
- RA_CYC, 2, cycles spent in RED_AMBER (110); must be ≥1.
- GREEN_CYC, 4, cycles spent in GREEN (001); must be ≥1.
- AMBER_CYC, 2, cycles spent in AMBER (010); must be ≥1.
- RW, derived localparam, result width = max(3, clog2(FACES+1)).

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, asynchronous, active-low reset (asserted when 0).
- sel, input, 1, output select: 1 = traffic, 0 = dice.
- button, input, 1, roll button; level-sensitive and already synchronised upstream.
- result, output, RW, selected engine value. Traffic codes are zero-extended to RW.
- dice_valid, output, 1, one-cycle pulse when a roll completes; forced to 0 while sel=1.
- phase_tick, output, 1, one-cycle pulse on every traffic phase change; forced to 0 while sel=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - dice value = 0, button_q = 0;
  - traffic phase = RED, dwell counter = 0;
  - dice_valid = 0, phase_tick = 0.
  - result therefore shows 0 (dice) or 100 (traffic) immediately.
- Both engines advance every cycle regardless of sel. Switching sel never disturbs either engine's state; result changes combinationally on sel.
- Dice engine, rising-edge priority:
  1. If value==0 or value>FACES (post-reset or corrupt), next value = 1, regardless of button.
  2. Else if button=1: value==FACES → 1, otherwise value+1 (wrap, no 0).
  3. Else hold.
- Dice roll report:
  - button_q registers button.
  - dice_valid (registered) = 1 in the cycle after an edge where button_q=1 and button=0, i.e. falling edge. The value is frozen during that cycle because button=0.
  - A button pulse of one cycle still produces exactly one increment and one dice_valid.
- Traffic engine:
  - State machine RED → RED_AMBER → GREEN → AMBER → RED, with output codes 100, 110, 001, 010.
  - Dwell counter counts 0..DWELL(phase)-1. On reaching DWELL-1, the next edge moves to the next phase, clears the counter, and sets phase_tick=1 for exactly that one cycle.
  - With all dwells at 1, the phase changes every cycle (legacy behaviour).
  - An unreachable state encoding recovers to RED with counter 0 on the next edge.
- Counter width = clog2(max dwell). No overflow is possible because each dwell is ≥1.
- Reset mid-operation: everything returns to reset values within the same cycle. After rst deasserts, the dice shows 1 after the first edge, and traffic starts a full RED dwell.
- button is ignored by the traffic engine. sel has no effect on engine state.

Decomposition:
- Package dice_traffic_pkg holds:
  - typedef enum of the traffic phases (RED, RED_AMBER, GREEN, AMBER);
  - 3-bit light-code constants LIGHT_RED=100, LIGHT_RA=110, LIGHT_GREEN=001, LIGHT_AMBER=010;
  - a function returning the dwell for a given phase.
- Sub-module traffic_seq: phase FSM, dwell counter and phase_tick, parametrised by the four dwell values.
- The dice logic and the output mux stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with sel=0.
  - Expect result=0, dice_valid=0.
  - After release, result=1 at the first edge even with button=0.
- Dice wrap, FACES=6, button=1 for 8 cycles from value 1.
  - Expect 2,3,4,5,6,1,2,3.
  - After button drops, value holds at 3 and dice_valid=1 for exactly one cycle.
- Dice corner cases:
  - Single-cycle button pulse → exactly one increment and one dice_valid.
  - Force a corrupt value of 7 via a FACES=6 hierarchical deposit → 1 on the next edge.
- Traffic dwell with defaults and sel=1 after reset:
  - Expect 100 for 4 cycles, 110 for 2, 001 for 4, 010 for 2, then 100.
  - phase_tick fires exactly 4 times per 12-cycle period.
- Mode isolation:
  - Toggle sel mid-GREEN while pressing button.
  - On return, traffic resumes with a continuous dwell count.
  - Dice advanced while hidden; dice_valid and phase_tick are each gated by sel.
- Async reset mid-AMBER, asserted between clock edges:
  - result goes to 100 without waiting for a clock edge.
  - A full RED dwell (4 cycles) follows release.

Source files
------------

// File: rtl/dice_traffic_gen_pkg.sv
// Shared types and constants for the dice roller / traffic-light generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dice_traffic_pkg;

  // 3-bit lamp codes {red, amber, green}
  localparam logic [2:0] LIGHT_RED   = 3'b100;
  localparam logic [2:0] LIGHT_RA    = 3'b110;
  localparam logic [2:0] LIGHT_GREEN = 3'b001;
  localparam logic [2:0] LIGHT_AMBER = 3'b010;

  // The phase encoding is the lamp code, so the FSM state drives the lamps
  // directly. The four unused encodings are treated as corruption.
  typedef enum logic [2:0] {
    RED       = LIGHT_RED,
    RED_AMBER = LIGHT_RA,
    GREEN     = LIGHT_GREEN,
    AMBER     = LIGHT_AMBER
  } phase_t;

  // Dwell in cycles for a phase. An illegal phase returns 1 so the
  // terminal-count compare stays well defined while the FSM recovers.
  function automatic int dwell(phase_t p, int red_cyc, int ra_cyc,
                               int green_cyc, int amber_cyc);
    case (p)
      RED:       return red_cyc;
      RED_AMBER: return ra_cyc;
      GREEN:     return green_cyc;
      AMBER:     return amber_cyc;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/dice_traffic_gen_if.sv
// Board-side bundle: select/button in, display value and event pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; the pulse outputs are fire-and-forget.
// Ports: sel, button (driven by master); result, dice_valid, phase_tick
// (driven by slave, i.e. the generator).
interface dice_traffic_gen_if #(
  parameter int RW = 3
);
  logic          sel;
  logic          button;
  logic [RW-1:0] result;
  logic          dice_valid;
  logic          phase_tick;

  modport master (
    output sel, button,
    input  result, dice_valid, phase_tick
  );

  modport slave (
    input  sel, button,
    output result, dice_valid, phase_tick
  );
endinterface

// File: rtl/dice_traffic_gen_traffic_seq.sv
// Four-phase traffic-light sequencer with a programmable dwell per phase.
// Latency: phase changes on the edge after the dwell counter hits dwell-1.
// Backpressure: none; free-running, phase_tick is a one-cycle pulse.
// Ports: clk, rst (async active-low), light (3-bit lamp code), phase_tick.
module traffic_seq
  import dice_traffic_pkg::*;
#(
  parameter int RED_CYC   = 4,
  parameter int RA_CYC    = 2,
  parameter int GREEN_CYC = 4,
  parameter int AMBER_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light,
  output logic       phase_tick
);

  localparam int MAX_A = (RED_CYC > RA_CYC) ? RED_CYC : RA_CYC;
  localparam int MAX_B = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
  localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  // All dwells of 1 would give a zero-width counter; keep one bit.
  localparam int CW    = (MAXD > 1) ? $clog2(MAXD) : 1;

  phase_t        state_q, state_d, succ;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          legal;
  logic          last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RED;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    tick_d  = 1'b0;
    legal   = 1'b1;
    succ    = RED;
    last    = (cnt_q == CW'(dwell(state_q, RED_CYC, RA_CYC,
                                  GREEN_CYC, AMBER_CYC) - 1));
    case (state_q)
      RED:       succ = RED_AMBER;
      RED_AMBER: succ = GREEN;
      GREEN:     succ = AMBER;
      AMBER:     succ = RED;
      default:   legal = 1'b0;
    endcase
    if (!legal) begin
      // Corrupt encoding: restart a clean RED dwell, no tick.
      state_d = RED;
      cnt_d   = '0;
    end else if (last) begin
      state_d = succ;
      cnt_d   = '0;
      tick_d  = 1'b1;
    end
  end

  assign light      = state_q;
  assign phase_tick = tick_q;

endmodule

// File: rtl/dice_traffic_gen.sv
// N-sided dice roller and traffic-light sequencer running side by side; sel muxes the display.
// Latency: dice value updates on the press edge, dice_valid one cycle after release; result mux is combinational.
// Backpressure: none; dice_valid and phase_tick are unacknowledged one-cycle pulses gated by sel.
// Ports: clk, rst (async active-low), bus (slave: sel, button in; result, dice_valid, phase_tick out).
module dice_traffic_gen
  import dice_traffic_pkg::*;
#(
  parameter int FACES     = 6,
  parameter int RED_CYC   = 4,
  parameter int RA_CYC    = 2,
  parameter int GREEN_CYC = 4,
  parameter int AMBER_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  dice_traffic_gen_if.slave  bus
);

  localparam int RW = ($clog2(FACES + 1) > 3) ? $clog2(FACES + 1) : 3;
  localparam logic [RW-1:0] FACES_V = RW'(FACES);

  logic [RW-1:0] value_q, value_d;
  logic          button_q;
  logic          valid_q;
  logic [2:0]    light;
  logic          tick;

  // Dice engine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q  <= '0;
      button_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      value_q  <= value_d;
      button_q <= bus.button;
      // Falling edge of the button reports the roll; the value is frozen
      // in that cycle because the button is already low.
      valid_q  <= button_q & ~bus.button;
    end
  end

  always_comb begin
    value_d = value_q;
    if (value_q == '0 || value_q > FACES_V) begin
      // Post-reset or corrupt value: snap to 1 irrespective of button.
      value_d = RW'(1);
    end else if (bus.button) begin
      value_d = (value_q == FACES_V) ? RW'(1) : value_q + RW'(1);
    end
  end

  // Traffic engine
  traffic_seq #(
    .RED_CYC   (RED_CYC),
    .RA_CYC    (RA_CYC),
    .GREEN_CYC (GREEN_CYC),
    .AMBER_CYC (AMBER_CYC)
  ) u_traffic_seq (
    .clk        (clk),
    .rst        (rst),
    .light      (light),
    .phase_tick (tick)
  );

  // Output mux; only presentation is affected by sel, never engine state.
  assign bus.result     = bus.sel ? RW'(light) : value_q;
  assign bus.dice_valid = valid_q & ~bus.sel;
  assign bus.phase_tick = tick & bus.sel;

endmodule

// File: tb/tb_dice_traffic_gen.sv
// Directed self-checking bench for dice_traffic_gen (FACES=6, dwells 4/2/4/2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dice_traffic_gen;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ticks;

  dice_traffic_gen_if #(.RW(3)) bus ();

  dice_traffic_gen #(
    .FACES     (6),
    .RED_CYC   (4),
    .RA_CYC    (2),
    .GREEN_CYC (4),
    .AMBER_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected lamp code after edge e of a fresh traffic run (4/2/4/2 dwells)
  function automatic logic [2:0] exp_light(input int e);
    int m;
    m = e % 12;
    if (m < 4)       return 3'b100;
    else if (m < 6)  return 3'b110;
    else if (m < 10) return 3'b001;
    else             return 3'b010;
  endfunction

  function automatic logic exp_tick(input int e);
    int m;
    m = e % 12;
    return (e > 0) && (m == 0 || m == 4 || m == 6 || m == 10);
  endfunction

  initial begin
    logic [2:0] wrap_exp [8];
    wrap_exp = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd3};

    // ---------------- Reset ----------------
    rst        = 1'b0;
    bus.sel    = 1'b0;
    bus.button = 1'b0;
    repeat (3) step();
    chk("reset_result_dice", 8'(bus.result), 8'd0);
    chk("reset_dice_valid", 8'(bus.dice_valid), 8'd0);
    bus.sel = 1'b1;
    #1;
    chk("reset_result_traffic", 8'(bus.result), 8'b100);
    bus.sel = 1'b0;
    #1;
    rst = 1'b1;
    step();
    chk("first_edge_one", 8'(bus.result), 8'd1);

    // ---------------- Dice wrap ----------------
    bus.button = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("wrap_%0d", i), 8'(bus.result), 8'(wrap_exp[i]));
      chk($sformatf("wrap_valid_%0d", i), 8'(bus.dice_valid), 8'd0);
    end
    bus.button = 1'b0;
    step();
    chk("release_hold", 8'(bus.result), 8'd3);
    chk("release_valid", 8'(bus.dice_valid), 8'd1);
    step();
    chk("release_valid_once", 8'(bus.dice_valid), 8'd0);
    chk("release_hold2", 8'(bus.result), 8'd3);

    // ---------------- Single-cycle pulse ----------------
    bus.button = 1'b1;
    step();
    chk("pulse_inc", 8'(bus.result), 8'd4);
    chk("pulse_no_valid_yet", 8'(bus.dice_valid), 8'd0);
    bus.button = 1'b0;
    step();
    chk("pulse_hold", 8'(bus.result), 8'd4);
    chk("pulse_valid", 8'(bus.dice_valid), 8'd1);
    step();
    chk("pulse_valid_once", 8'(bus.dice_valid), 8'd0);
    chk("pulse_hold2", 8'(bus.result), 8'd4);

    // ---------------- Corrupt value ----------------
    dut.value_q = 3'd7;
    #1;
    chk("corrupt_visible", 8'(bus.result), 8'd7);
    step();
    chk("corrupt_recover", 8'(bus.result), 8'd1);

    // ---------------- Traffic dwell ----------------
    rst     = 1'b0;
    bus.sel = 1'b1;
    #1;
    chk("traffic_reset", 8'(bus.result), 8'b100);
    chk("traffic_reset_tick", 8'(bus.phase_tick), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    ticks = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("light_e%0d", e), 8'(bus.result), 8'(exp_light(e)));
      chk($sformatf("tick_e%0d", e), 8'(bus.phase_tick), 8'(exp_tick(e)));
      if (bus.phase_tick) ticks++;
    end
    chk("ticks_per_period", 8'(ticks), 8'd4);

    // ---------------- Mode isolation ----------------
    repeat (7) step();                                 // edge 19: mid-GREEN
    chk("iso_mid_green", 8'(bus.result), 8'b001);
    bus.sel    = 1'b0;
    bus.button = 1'b1;
    #1;
    chk("iso_dice_shown", 8'(bus.result), 8'd1);
    step();                                            // edge 20
    chk("iso_dice_2", 8'(bus.result), 8'd2);
    step();                                            // edge 21
    chk("iso_dice_3", 8'(bus.result), 8'd3);
    step();                                            // edge 22: GREEN->AMBER tick hidden
    chk("iso_dice_4", 8'(bus.result), 8'd4);
    chk("iso_tick_gated", 8'(bus.phase_tick), 8'd0);
    bus.sel    = 1'b1;
    bus.button = 1'b0;
    step();                                            // edge 23: roll reported, hidden
    chk("iso_traffic_amber", 8'(bus.result), 8'b010);
    chk("iso_valid_gated", 8'(bus.dice_valid), 8'd0);
    bus.sel = 1'b0;
    #1;
    chk("iso_valid_shown", 8'(bus.dice_valid), 8'd1);
    chk("iso_dice_held", 8'(bus.result), 8'd4);
    bus.sel = 1'b1;
    step();                                            // edge 24: AMBER->RED
    chk("iso_red", 8'(bus.result), 8'b100);
    chk("iso_tick_shown", 8'(bus.phase_tick), 8'd1);

    // ---------------- Async reset mid-AMBER ----------------
    repeat (10) step();                                // edge 34: AMBER
    chk("amber_before_reset", 8'(bus.result), 8'b010);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_red", 8'(bus.result), 8'b100);
    bus.sel = 1'b0;
    #1;
    chk("async_reset_dice", 8'(bus.result), 8'd0);
    bus.sel = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("post_reset_e%0d", e), 8'(bus.result), 8'(exp_light(e)));
    end
    chk("post_reset_tick", 8'(bus.phase_tick), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
